// File: rtl/pc_ctrl.sv
// PC sequencing controller: arbitrates trap entry, mret, branches and stalls,
// and drives the PC register's jump_en / jump_addr.
module pc_ctrl #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned IRQ_CAUSE = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              stall,
   input  logic              br_en,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              exc_req,
   input  logic [3:0]        exc_cause,
   input  logic              irq_req,
   input  logic              irq_en,
   input  logic              mret_req,
   input  logic [ADDR_W-1:0] mepc_in,
   input  logic [ADDR_W-1:0] mtvec_in,
   output logic              jump_en,
   output logic [ADDR_W-1:0] jump_addr,
   output logic              flush,
   output logic              mepc_we,
   output logic [ADDR_W-1:0] mepc_wdata,
   output logic              mcause_we,
   output logic [31:0]       mcause_wdata,
   output logic              irq_ack,
   output logic              trap_busy
);

   typedef enum logic [1:0] {RUN, PEND, TRAP} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pend_addr, pend_nxt;
   logic              take_exc, take_irq;

   // mtvec low two bits are mode bits; the vector base is word aligned
   logic [ADDR_W-1:0] trap_vec;
   assign trap_vec = mtvec_in & ~ADDR_W'(3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         pend_addr <= '0;
      end else begin
         state     <= state_nxt;
         pend_addr <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pend_nxt     = pend_addr;
      jump_en      = 1'b0;
      jump_addr    = '0;
      flush        = 1'b0;
      mepc_we      = 1'b0;
      mepc_wdata   = '0;
      mcause_we    = 1'b0;
      mcause_wdata = '0;
      irq_ack      = 1'b0;
      trap_busy    = 1'b0;

      take_exc = exc_req && (state != TRAP);
      take_irq = !exc_req && (state == RUN) && irq_req && irq_en && !stall;

      if (take_exc || take_irq) begin
         // save cycle: hold PC, kill the current instruction, record the cause
         jump_en    = 1'b1;
         jump_addr  = pc_in;
         flush      = 1'b1;
         mepc_we    = 1'b1;
         mepc_wdata = pc_in;
         mcause_we  = 1'b1;
         if (take_exc) begin
            mcause_wdata = {1'b0, 27'b0, exc_cause};
         end else begin
            mcause_wdata = {1'b1, 27'b0, 4'(IRQ_CAUSE)};
            irq_ack      = 1'b1;
         end
         pend_nxt  = '0;
         state_nxt = TRAP;
      end else begin
         unique case (state)
            RUN: begin
               if (mret_req) begin
                  jump_en   = 1'b1;
                  jump_addr = mepc_in;
               end else if (br_en && !stall) begin
                  jump_en   = 1'b1;
                  jump_addr = br_addr;
               end else if (br_en && stall) begin
                  jump_en   = 1'b1;
                  jump_addr = pc_in;
                  pend_nxt  = br_addr;
                  state_nxt = PEND;
               end else if (stall) begin
                  jump_en   = 1'b1;
                  jump_addr = pc_in;
               end
            end
            PEND: begin
               jump_en = 1'b1;
               if (stall) begin
                  jump_addr = pc_in;
               end else begin
                  jump_addr = pend_addr;
                  pend_nxt  = '0;
                  state_nxt = RUN;
               end
            end
            TRAP: begin
               jump_en   = 1'b1;
               jump_addr = trap_vec;
               flush     = 1'b1;
               trap_busy = 1'b1;
               state_nxt = RUN;
            end
            default: state_nxt = RUN;
         endcase
      end

      // outputs are quiet while reset is held
      if (!rst_n) begin
         jump_en      = 1'b0;
         jump_addr    = '0;
         flush        = 1'b0;
         mepc_we      = 1'b0;
         mepc_wdata   = '0;
         mcause_we    = 1'b0;
         mcause_wdata = '0;
         irq_ack      = 1'b0;
         trap_busy    = 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed vector table, reset corner sequence, and
// randomized traffic checked against a behavioural model.
module tb_pc_ctrl;

   typedef struct {
      logic        stall, br_en, exc_req, irq_req, irq_en, mret_req;
      logic [31:0] br_addr, pc, mepc, mtvec;
      logic [3:0]  cause;
   } in_t;

   typedef struct {
      logic        jump_en, flush, mepc_we, mcause_we, irq_ack, trap_busy;
      logic [31:0] jump_addr, mepc_wdata, mcause_wdata;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_in, br_addr, mepc_in, mtvec_in;
   logic        stall, br_en, exc_req, irq_req, irq_en, mret_req;
   logic [3:0]  exc_cause;
   logic        jump_en, flush, mepc_we, mcause_we, irq_ack, trap_busy;
   logic [31:0] jump_addr, mepc_wdata, mcause_wdata;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model state: trap-vector cycle pending, queued branch target
   bit          m_trap;
   logic [31:0] m_pend[$];

   always #5 clk = ~clk;

   pc_ctrl #(.ADDR_W(32), .IRQ_CAUSE(11)) dut (
      .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .stall(stall), .br_en(br_en),
      .br_addr(br_addr), .exc_req(exc_req), .exc_cause(exc_cause),
      .irq_req(irq_req), .irq_en(irq_en), .mret_req(mret_req),
      .mepc_in(mepc_in), .mtvec_in(mtvec_in), .jump_en(jump_en),
      .jump_addr(jump_addr), .flush(flush), .mepc_we(mepc_we),
      .mepc_wdata(mepc_wdata), .mcause_we(mcause_we),
      .mcause_wdata(mcause_wdata), .irq_ack(irq_ack), .trap_busy(trap_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_out(input string tag, input exp_t e);
      chk({tag, " jump_en"}, 32'(jump_en), 32'(e.jump_en));
      if (e.jump_en) chk({tag, " jump_addr"}, jump_addr, e.jump_addr);
      chk({tag, " flush"}, 32'(flush), 32'(e.flush));
      chk({tag, " mepc_we"}, 32'(mepc_we), 32'(e.mepc_we));
      if (e.mepc_we) chk({tag, " mepc_wdata"}, mepc_wdata, e.mepc_wdata);
      chk({tag, " mcause_we"}, 32'(mcause_we), 32'(e.mcause_we));
      if (e.mcause_we) chk({tag, " mcause_wdata"}, mcause_wdata, e.mcause_wdata);
      chk({tag, " irq_ack"}, 32'(irq_ack), 32'(e.irq_ack));
      chk({tag, " trap_busy"}, 32'(trap_busy), 32'(e.trap_busy));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " jump_en"}, 32'(jump_en), 32'd0);
      chk({tag, " jump_addr"}, jump_addr, 32'd0);
      chk({tag, " flush"}, 32'(flush), 32'd0);
      chk({tag, " mepc_we"}, 32'(mepc_we), 32'd0);
      chk({tag, " mcause_we"}, 32'(mcause_we), 32'd0);
      chk({tag, " irq_ack"}, 32'(irq_ack), 32'd0);
      chk({tag, " trap_busy"}, 32'(trap_busy), 32'd0);
   endtask

   task automatic drive(input in_t i);
      stall = i.stall; br_en = i.br_en; br_addr = i.br_addr;
      exc_req = i.exc_req; exc_cause = i.cause; irq_req = i.irq_req;
      irq_en = i.irq_en; mret_req = i.mret_req; pc_in = i.pc;
      mepc_in = i.mepc; mtvec_in = i.mtvec;
   endtask

   function automatic in_t mk_in(bit s, bit b, logic [31:0] ba, bit x, logic [3:0] c,
                                 bit q, bit qe, bit m, logic [31:0] pc);
      in_t i;
      i.stall = s; i.br_en = b; i.br_addr = ba; i.exc_req = x; i.cause = c;
      i.irq_req = q; i.irq_en = qe; i.mret_req = m; i.pc = pc;
      i.mepc = 32'h80; i.mtvec = 32'h1001;
      return i;
   endfunction

   function automatic exp_t mk_exp(bit je, logic [31:0] ja, bit fl, bit mw, logic [31:0] md,
                                   bit cw, logic [31:0] cd, bit ack, bit busy);
      exp_t e;
      e.jump_en = je; e.jump_addr = ja; e.flush = fl; e.mepc_we = mw;
      e.mepc_wdata = md; e.mcause_we = cw; e.mcause_wdata = cd;
      e.irq_ack = ack; e.trap_busy = busy;
      return e;
   endfunction

   // reference model straight from the sequencing rules; updates model state
   function automatic exp_t model_step(in_t i);
      exp_t e = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
      bit pending = (m_pend.size() > 0);
      if (m_trap) begin
         e.jump_en = 1; e.jump_addr = {i.mtvec[31:2], 2'b00};
         e.flush = 1; e.trap_busy = 1;
         m_trap = 0;
      end else if (i.exc_req || (!pending && i.irq_req && i.irq_en && !i.stall)) begin
         e.jump_en = 1; e.jump_addr = i.pc; e.flush = 1;
         e.mepc_we = 1; e.mepc_wdata = i.pc; e.mcause_we = 1;
         if (i.exc_req) e.mcause_wdata = {28'd0, i.cause};
         else begin
            e.mcause_wdata = 32'h8000_000B;
            e.irq_ack = 1;
         end
         m_pend.delete();
         m_trap = 1;
      end else if (pending) begin
         e.jump_en = 1;
         e.jump_addr = i.stall ? i.pc : m_pend.pop_front();
      end else if (i.mret_req) begin
         e.jump_en = 1; e.jump_addr = i.mepc;
      end else if (i.br_en && !i.stall) begin
         e.jump_en = 1; e.jump_addr = i.br_addr;
      end else if (i.stall) begin
         e.jump_en = 1; e.jump_addr = i.pc;
         if (i.br_en) m_pend.push_back(i.br_addr);
      end
      return e;
   endfunction

   vec_t tbl[$];

   initial begin
      in_t  ri;
      exp_t re;

      rst_n = 1'b0;
      drive(mk_in(0, 0, 0, 1, 4'd3, 0, 0, 0, 32'h100));
      #7;
      check_zero("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h100));
      @(posedge clk);
      #1;

      //                   stall br  br_addr     exc cause irq en mret pc
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 0, 0, 0, 32'h100), mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 1, 32'h200,    0, 0, 0, 0, 0, 32'h100), mk_exp(1, 32'h200, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 0, 0, 0, 32'h200), mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(1, 1, 32'h300,    0, 0, 0, 0, 0, 32'h120), mk_exp(1, 32'h120, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(1, 1, 32'h400,    0, 0, 0, 0, 0, 32'h120), mk_exp(1, 32'h120, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(1, 0, 0,          0, 0, 0, 0, 0, 32'h120), mk_exp(1, 32'h120, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 0, 0, 0, 32'h120), mk_exp(1, 32'h300, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 0, 0, 0, 32'h300), mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 1, 32'h500,    1, 2, 0, 0, 0, 32'h400), mk_exp(1, 32'h400, 1, 1, 32'h400, 1, 32'h2, 0, 0)});
      tbl.push_back('{mk_in(0, 1, 32'h500,    1, 7, 0, 0, 1, 32'h400), mk_exp(1, 32'h1000, 1, 0, 0, 0, 0, 0, 1)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 0, 0, 0, 32'h1000), mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 1, 0, 0, 32'h1000), mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(1, 0, 0,          0, 0, 1, 1, 0, 32'h1000), mk_exp(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 1, 1, 0, 32'h1004), mk_exp(1, 32'h1004, 1, 1, 32'h1004, 1, 32'h8000000B, 1, 0)});
      tbl.push_back('{mk_in(0, 1, 32'h600,    0, 0, 1, 1, 0, 32'h1004), mk_exp(1, 32'h1000, 1, 0, 0, 0, 0, 0, 1)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 1, 0, 0, 32'h1000), mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 1, 32'h900,    0, 0, 0, 0, 1, 32'h1000), mk_exp(1, 32'h80, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(1, 1, 32'h700,    0, 0, 0, 0, 0, 32'h130), mk_exp(1, 32'h130, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(1, 0, 0,          1, 5, 0, 0, 0, 32'h130), mk_exp(1, 32'h130, 1, 1, 32'h130, 1, 32'h5, 0, 0)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 0, 0, 0, 32'h130), mk_exp(1, 32'h1000, 1, 0, 0, 0, 0, 0, 1)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 0, 0, 0, 32'h1000), mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(1, 1, 32'h800,    0, 0, 0, 0, 0, 32'h140), mk_exp(1, 32'h140, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 1, 1, 1, 32'h140), mk_exp(1, 32'h800, 0, 0, 0, 0, 0, 0, 0)});
      tbl.push_back('{mk_in(0, 0, 0,          0, 0, 0, 0, 0, 32'h800), mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)});

      foreach (tbl[k]) begin
         drive(tbl[k].i);
         @(negedge clk);
         check_out($sformatf("vec%0d", k), tbl[k].e);
         @(posedge clk);
         #1;
      end

      // async reset landing in the TRAP cycle
      drive(mk_in(0, 0, 0, 1, 4'd1, 0, 0, 0, 32'h400));
      @(posedge clk);
      #1;
      drive(mk_in(0, 1, 32'h500, 0, 0, 0, 0, 0, 32'h400));
      #2;
      chk("pre_rst trap_busy", 32'(trap_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_zero("rst_in_trap");
      @(negedge clk);
      drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h100));
      rst_n = 1'b1;
      #1;
      check_out("post_rst", mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      drive(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h100));
      @(negedge clk);
      check_out("post_rst_mret", mk_exp(1, 32'h80, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;

      // randomized traffic against the model, model starts from reset
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      m_trap = 0;
      m_pend.delete();
      for (int n = 0; n < 3000; n++) begin
         ri.stall    = ($urandom_range(0, 99) < 35);
         ri.br_en    = ($urandom_range(0, 99) < 35);
         ri.exc_req  = ($urandom_range(0, 99) < 8);
         ri.irq_req  = ($urandom_range(0, 99) < 25);
         ri.irq_en   = ($urandom_range(0, 99) < 50);
         ri.mret_req = ($urandom_range(0, 99) < 10);
         ri.cause    = 4'($urandom);
         ri.br_addr  = $urandom;
         ri.pc       = $urandom & 32'hFFFF_FFFC;
         ri.mepc     = $urandom;
         ri.mtvec    = $urandom;
         drive(ri);
         @(negedge clk);
         re = model_step(ri);
         check_out($sformatf("rnd%0d", n), re);
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter sequencing controller for the single-cycle core. It sits directly in front of the PC register and owns that register's `jump_en` / `jump_addr` inputs. It arbitrates between exception, interrupt, `mret`, branch/jump, stall and sequential fetch. It also runs a two-cycle trap-entry sequence that writes `mepc`/`mcause` and redirects fetch to `mtvec`.

## Interface
- `ADDR_W`, 32, width of the PC and of all address ports.
- `IRQ_CAUSE`, 11, low bits of `mcause` for an external interrupt.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low; clock `clk`.
- `pc_in`  in  ADDR_W  current PC, the PC register output.
- `stall`  in  1  freeze fetch (hold the PC).
- `br_en`  in  1  branch/jump taken, from execute.
- `br_addr`  in  ADDR_W  branch/jump target.
- `exc_req`  in  1  synchronous exception on the instruction at `pc_in`.
- `exc_cause`  in  4  exception code.
- `irq_req`  in  1  external interrupt, level.
- `irq_en`  in  1  `mstatus.MIE`.
- `mret_req`  in  1  `mret` executing.
- `mepc_in`  in  ADDR_W  current `mepc` CSR.
- `mtvec_in`  in  ADDR_W  current `mtvec` CSR.
- `jump_en`  out  1  to the PC register; load `jump_addr`.
- `jump_addr`  out  ADDR_W  next PC when `jump_en` = 1.
- `flush`  out  1  kill the instruction currently at `pc_in`; suppress its writeback.
- `mepc_we`  out  1  `mepc` write strobe.
- `mepc_wdata`  out  ADDR_W  value written to `mepc`.
- `mcause_we`  out  1  `mcause` write strobe.
- `mcause_wdata`  out  32  bit31 = interrupt; bits 3:0 = cause; other bits 0.
- `irq_ack`  out  1  one-cycle pulse when an interrupt is taken.
- `trap_busy`  out  1  high while in TRAP.

## Operation
- FSM states: RUN, PEND, TRAP. Registered state: state, pending target `pend_addr` (ADDR_W). All outputs are combinational from state and inputs.
- RUN priority, highest first:
  - `exc_req`: trap entry.
  - `irq_req & irq_en & !stall`: trap entry.
  - `mret_req`: `jump_en`=1, `jump_addr`=`mepc_in`.
  - `br_en & !stall`: `jump_en`=1, `jump_addr`=`br_addr`.
  - `br_en & stall`: `pend_addr`←`br_addr`; `jump_en`=1, `jump_addr`=`pc_in`; next state PEND.
  - `stall`: `jump_en`=1, `jump_addr`=`pc_in`.
  - Otherwise: `jump_en`=0, and the PC increments by 4.
- Trap-entry cycle, taken in RUN or PEND:
  - `mepc_we`=1, `mepc_wdata`=`pc_in`.
  - `mcause_we`=1. Exception: `mcause_wdata`={1'b0, 27'b0, `exc_cause`}. Interrupt: `mcause_wdata`={1'b1, 27'b0, `IRQ_CAUSE`[3:0]}, and `irq_ack`=1.
  - `jump_en`=1, `jump_addr`=`pc_in`, `flush`=1.
  - Next state TRAP. Any pending target is discarded.
- TRAP: `jump_en`=1, `jump_addr`={`mtvec_in`[ADDR_W-1:2], 2'b00}, `flush`=1, `trap_busy`=1. Next state is always RUN. `br_en`, `mret_req`, `irq_req` and `exc_req` are all ignored.
- PEND:
  - `exc_req` → trap entry.
  - `stall`=1 → `jump_en`=1, `jump_addr`=`pc_in`. Further `br_en` is ignored; the oldest target wins.
  - `stall`=0 → `jump_en`=1, `jump_addr`=`pend_addr`, next state RUN.
  - Interrupts and `mret_req` are not taken in PEND.
- No address arithmetic beyond the `mtvec` alignment mask. Targets pass through unmodified. Branch-target misalignment is execute's responsibility.

## Timing
- Reset (asynchronous): state=RUN, `pend_addr`=0. While `rst_n`=0, all strobes and `jump_en` are forced to 0 and `jump_addr`=0.
- Reset asserted mid-trap or mid-PEND returns to RUN, and the pending target is lost.
- Redirect latency: 0 cycles. `jump_en`/`jump_addr` are valid in the same cycle as the request, and the PC register takes the new value at the next `clk` edge.
- Trap latency: 2 cycles from `exc_req` to PC = `mtvec`. Cycle 0 is the save cycle (PC held); cycle 1 is the TRAP state, with the PC loaded at the end of cycle 1.
- `irq_ack`, `mepc_we` and `mcause_we` are single-cycle pulses, never back-to-back.
- `exc_req` together with `br_en`: the exception wins and the branch is dropped.
- `mret_req` together with `br_en`: `mret` wins.

## Test plan
- Idle: `pc_in`=0x100, no requests → `jump_en`=0, `flush`=0, all strobes 0.
- Branch: `br_en`=1, `br_addr`=0x200 in RUN → same-cycle `jump_en`=1, `jump_addr`=0x200; state remains RUN.
- Branch during stall, `pc_in`=0x120:
  - `stall`=1 for 3 cycles, with `br_en`=1, `br_addr`=0x300 in cycle 0 and `br_en`=1, `br_addr`=0x400 in cycle 1.
  - Cycles 0–2 → `jump_addr`=0x120.
  - Cycle 3 (`stall`=0) → `jump_addr`=0x300, then state RUN.
- Exception:
  - `exc_req`=1, `exc_cause`=2, `pc_in`=0x400, `mtvec_in`=0x1001.
  - Cycle 0 → `mepc_wdata`=0x400, `mcause_wdata`=0x00000002, `jump_addr`=0x400, `flush`=1.
  - Cycle 1 → `jump_addr`=0x1000, `trap_busy`=1.
  - Cycle 2 → RUN.
- Interrupt gating:
  - `irq_req`=1 with `irq_en`=0 → no trap.
  - Set `irq_en`=1 with `stall`=1 → no trap.
  - Drop `stall` → `irq_ack` pulse, `mcause_wdata`=0x8000000B.
  - `br_en` in the following TRAP cycle is ignored.
- Async reset asserted in the TRAP cycle → outputs 0 immediately. After release: RUN, `jump_en`=0, and a subsequent `mret_req` with `mepc_in`=0x80 gives `jump_addr`=0x80.
